// File: rtl/hilo_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the execute stage.
// Operands are latched at start; the result is written to HI/LO on the last busy cycle.
module hilo_mdu #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic             op_valid,
  input  logic             req,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             md_stall,
  output logic [WIDTH-1:0] hilo_out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFLO  = 4'd5,
    OP_MFHI  = 4'd6,
    OP_MTLO  = 4'd7,
    OP_MTHI  = 4'd8
  } op_e;

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q;

  logic accept, start, done;
  logic is_md_op, is_mult_op;

  assign is_md_op   = (op >= OP_MULT) && (op <= OP_DIVU);
  assign is_mult_op = (op == OP_MULT) || (op == OP_MULTU);
  assign accept     = op_valid && !req && !busy_q;
  assign start      = accept && is_md_op;
  assign done       = busy_q && (cnt_q == CW'(1));

  assign busy     = busy_q;
  assign md_stall = op_valid && (op >= OP_MULT) && (op <= OP_MTHI) && busy_q;

  // Sign-extending to 2*WIDTH lets a single multiplier serve both mult and multu.
  logic               mul_sext;
  logic [2*WIDTH-1:0] mul_a, mul_b, product;

  assign mul_sext = (op_q == OP_MULT);
  assign mul_a    = {{WIDTH{mul_sext & a_q[WIDTH-1]}}, a_q};
  assign mul_b    = {{WIDTH{mul_sext & b_q[WIDTH-1]}}, b_q};
  assign product  = mul_a * mul_b;

  // Zero divisor and the signed-overflow case both divide by 1 instead: the
  // overflow case then yields MIN_NEG / 0 directly, and zero suppresses the write.
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] b_div, quot_s, rem_s, quot_u, rem_u;

  assign div_zero = (b_q == '0);
  assign div_ovf  = (op_q == OP_DIV) && (a_q == MIN_NEG) && (&b_q);
  assign b_div    = (div_zero || div_ovf) ? WIDTH'(1) : b_q;
  assign quot_s   = $signed(a_q) / $signed(b_div);
  assign rem_s    = $signed(a_q) % $signed(b_div);
  assign quot_u   = a_q / b_div;
  assign rem_u    = a_q % b_div;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= OP_NONE;
      a_q    <= '0;
      b_q    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (start) begin
        a_q    <= rs_val;
        b_q    <= rt_val;
        op_q   <= op_e'(op);
        cnt_q  <= is_mult_op ? MULT_CNT : DIV_CNT;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        cnt_q <= cnt_q - CW'(1);
        if (done) busy_q <= 1'b0;
      end

      if (done) begin
        case (op_q)
          OP_MULT, OP_MULTU: {hi, lo} <= product;
          OP_DIV: if (!div_zero) begin
            hi <= rem_s;
            lo <= quot_s;
          end
          OP_DIVU: if (!div_zero) begin
            hi <= rem_u;
            lo <= quot_u;
          end
          default: ;
        endcase
      end else if (accept && op == OP_MTHI) begin
        hi <= rs_val;
      end else if (accept && op == OP_MTLO) begin
        lo <= rs_val;
      end
    end
  end

  always_comb begin
    hilo_out = '0;
    if (op == OP_MFLO)      hilo_out = lo;
    else if (op == OP_MFHI) hilo_out = hi;
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu: latency, results, stall handshake, req gating and reset.
// A second instance with unit latency exercises the minimum-latency corner.
module tb_hilo_mdu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   op;
  logic         op_valid;
  logic         req;
  logic [W-1:0] rs_val, rt_val;
  logic         busy, md_stall;
  logic [W-1:0] hilo_out, hi, lo;
  logic         busy1, md_stall1;
  logic [W-1:0] hilo_out1, hi1, lo1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hilo_mdu #(.WIDTH(W), .MULT_LAT(5), .DIV_LAT(10)) u_dut (
    .clk(clk), .reset(reset), .op(op), .op_valid(op_valid), .req(req),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .md_stall(md_stall),
    .hilo_out(hilo_out), .hi(hi), .lo(lo)
  );

  hilo_mdu #(.WIDTH(W), .MULT_LAT(1), .DIV_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .op(op), .op_valid(op_valid), .req(req),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy1), .md_stall(md_stall1),
    .hilo_out(hilo_out1), .hi(hi1), .lo(lo1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op = 4'd0; op_valid = 1'b0; req = 1'b0; rs_val = '0; rt_val = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy === 1'b1 || busy1 === 1'b1) && n < 40) begin n++; tick(); end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL wait_idle: busy=%b required 0 within 40 cycles", busy);
    end
  endtask

  // Issues one md op, counts busy cycles, then compares latency and HI/LO.
  task automatic run_md(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int lat, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input string name);
    int n = 0;
    op = o; op_valid = 1'b1; rs_val = a; rt_val = b;
    tick();
    idle();
    while (busy === 1'b1 && n < 40) begin n++; tick(); end
    checks++;
    if (n != lat) begin failures++; $display("FAIL %s latency: got %0d required %0d", name, n, lat); end
    checks++;
    if (hi !== eh) begin failures++; $display("FAIL %s hi: got %h required %h", name, hi, eh); end
    checks++;
    if (lo !== el) begin failures++; $display("FAIL %s lo: got %h required %h", name, lo, el); end
  endtask

  task automatic write_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
    op = 4'd8; op_valid = 1'b1; rs_val = h; tick();
    op = 4'd7; rs_val = l; tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    op = 4'd0; op_valid = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b required 0", busy); end
    checks++;
    if (hi !== '0 || lo !== '0) begin
      failures++; $display("FAIL reset hilo: got hi=%h lo=%h required 0/0", hi, lo);
    end
    checks++;
    if (md_stall !== 1'b0 || hilo_out !== '0) begin
      failures++; $display("FAIL reset outputs: got md_stall=%b hilo_out=%h required 0/0", md_stall, hilo_out);
    end
    idle();
  endtask

  task automatic test_mult();
    run_md(4'd1, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult");
    run_md(4'd2, 32'hFFFF_FFFD, 32'd7, 5, 32'h0000_0006, 32'hFFFF_FFEB, "multu");
  endtask

  task automatic test_div();
    run_md(4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    run_md(4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD, "div_negdivisor");
    run_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000, "div_ovf");
    run_md(4'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14, "divu");
    write_hilo(32'h11, 32'h22);
    run_md(4'd4, 32'd7, 32'd0, 10, 32'h11, 32'h22, "divu_zero");
    run_md(4'd3, 32'd7, 32'd0, 10, 32'h11, 32'h22, "div_zero");
  endtask

  task automatic test_mf_stall();
    int n = 0;
    op = 4'd1; op_valid = 1'b1; rs_val = 32'd6; rt_val = 32'd7;
    tick();
    op = 4'd5; rs_val = '0; rt_val = '0;
    #1;
    while (md_stall === 1'b1 && n < 40) begin n++; tick(); end
    checks++;
    if (n != 5) begin failures++; $display("FAIL mflo stall cycles: got %0d required 5", n); end
    checks++;
    if (hilo_out !== 32'd42) begin failures++; $display("FAIL mflo value: got %h required %h", hilo_out, 32'd42); end
    op = 4'd6;
    #1;
    checks++;
    if (hilo_out !== 32'd0 || md_stall !== 1'b0) begin
      failures++; $display("FAIL mfhi value: got %h stall=%b required 0/0", hilo_out, md_stall);
    end
    idle();
    tick();
  endtask

  task automatic test_mt_req();
    logic [W-1:0] old_hi;
    old_hi = hi;
    op = 4'd8; op_valid = 1'b1; rs_val = 32'hDEAD_BEEF; req = 1'b1;
    tick();
    checks++;
    if (hi !== old_hi) begin failures++; $display("FAIL mthi_req hi: got %h required %h", hi, old_hi); end
    req = 1'b0;
    tick();
    checks++;
    if (hi !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mthi hi: got %h required deadbeef", hi); end
    op = 4'd6; rs_val = '0;
    #1;
    checks++;
    if (hilo_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mfhi_after_mt: got %h required deadbeef", hilo_out); end
    op = 4'd7; rs_val = 32'h1234_5678;
    tick();
    op = 4'd5;
    #1;
    checks++;
    if (hilo_out !== 32'h1234_5678) begin failures++; $display("FAIL mflo_after_mt: got %h required 12345678", hilo_out); end
    idle();
  endtask

  task automatic test_req_inflight();
    op = 4'd4; op_valid = 1'b1; rs_val = 32'd50; rt_val = 32'd8;
    tick();
    op = 4'd0; op_valid = 1'b0; req = 1'b1;
    tick(); tick();
    req = 1'b0;
    wait_idle();
    checks++;
    if (hi !== 32'd2 || lo !== 32'd6) begin
      failures++; $display("FAIL req_inflight: got hi=%h lo=%h required 2/6", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int m = 0;
    op = 4'd2; op_valid = 1'b1; rs_val = 32'd2; rt_val = 32'd3;
    tick();
    op = 4'd1; rs_val = 32'hFFFF_FFFF; rt_val = 32'd5;
    #1;
    while (md_stall === 1'b1 && n < 40) begin n++; tick(); end
    checks++;
    if (n != 5) begin failures++; $display("FAIL b2b stall cycles: got %0d required 5", n); end
    checks++;
    if (lo !== 32'd6) begin failures++; $display("FAIL b2b first lo: got %h required 6", lo); end
    tick();
    idle();
    while (busy === 1'b1 && m < 40) begin m++; tick(); end
    checks++;
    if (m != 5) begin failures++; $display("FAIL b2b second latency: got %0d required 5", m); end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFB) begin
      failures++; $display("FAIL b2b second result: got hi=%h lo=%h required ffffffff/fffffffb", hi, lo);
    end
  endtask

  task automatic test_lat1();
    op = 4'd2; op_valid = 1'b1; rs_val = 32'd9; rt_val = 32'd9;
    tick();
    idle();
    checks++;
    if (busy1 !== 1'b1) begin failures++; $display("FAIL lat1 busy first cycle: got %b required 1", busy1); end
    tick();
    checks++;
    if (busy1 !== 1'b0 || lo1 !== 32'd81 || hi1 !== 32'd0) begin
      failures++; $display("FAIL lat1 result: got busy=%b hi=%h lo=%h required 0/0/51", busy1, hi1, lo1);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    write_hilo(32'hAAAA_0001, 32'hBBBB_0002);
    op = 4'd3; op_valid = 1'b1; rs_val = 32'd100; rt_val = 32'd7;
    tick();
    idle();
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
      failures++; $display("FAIL reset_mid: got busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
    end
    repeat (12) tick();
    checks++;
    if (hi !== '0 || lo !== '0) begin
      failures++; $display("FAIL reset_mid late write: got hi=%h lo=%h required 0/0", hi, lo);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_mult();
    test_div();
    test_mf_stall();
    test_mt_req();
    test_req_inflight();
    test_back_to_back();
    test_lat1();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
